// File: rtl/demux_reg_pkg.sv
// demux_reg_pkg: shared widths and select-width helper for the demux
package demux_reg_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = 8;
  function automatic int sel_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register; drain and load in one cycle keeps it full
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) q <= d;
      valid <= load | (valid & ~drain);
    end
  end
endmodule

// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-N stream demux with per-port slots and drop accounting
module demux_reg
  import demux_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = 2,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               sel_err
);
  // padded to the full select range so out-of-range selects read as not busy
  logic [(1 << SEL_W)-1:0] busy;
  logic legal, take, drop;
  always_comb begin
    busy = '0;
    for (int k = 0; k < N; k++) busy[k] = out_valid[k] & ~out_ready[k];
  end
  assign legal    = int'(in_sel) < N;
  assign in_ready = ~busy[in_sel];
  assign take     = in_valid & in_ready;
  assign drop     = take & ~legal;
  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (take && in_sel == SEL_W'(k)),
      .drain(out_valid[k] & out_ready[k]),
      .d    (in_data),
      .q    (out_data[k*WIDTH +: WIDTH]),
      .valid(out_valid[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
      sel_err <= sel_err | drop;
    end
  end
endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: directed and random scoreboard checks on N=2 and N=3 instances
module tb_demux_reg;
  logic clk, rst;
  logic [7:0] a_data;
  logic [0:0] a_sel;
  logic a_valid, a_ready, a_err;
  logic [15:0] a_odata;
  logic [1:0] a_ovalid, a_oready;
  logic [7:0] a_drop;
  logic [7:0] b_data;
  logic [1:0] b_sel;
  logic b_valid, b_ready, b_err;
  logic [23:0] b_odata;
  logic [2:0] b_ovalid, b_oready;
  logic [7:0] b_drop;
  int pass_cnt, total_cnt;
  logic [7:0] sbq [3][$];

  demux_reg #(.WIDTH(8), .N(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
    .drop_cnt(a_drop), .sel_err(a_err)
  );
  demux_reg #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
    .drop_cnt(b_drop), .sel_err(b_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++; if (a_ovalid !== 2'b00 || a_odata !== 16'h0) $display("FAIL reset_a_out got v=%b d=%h exp v=00 d=0000", a_ovalid, a_odata); else pass_cnt++;
    total_cnt++; if (b_ovalid !== 3'b000 || b_odata !== 24'h0) $display("FAIL reset_b_out got v=%b d=%h exp v=000 d=000000", b_ovalid, b_odata); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd0 || a_err !== 1'b0 || b_drop !== 8'd0 || b_err !== 1'b0) $display("FAIL reset_drop got a=%0d/%b b=%0d/%b exp 0/0", a_drop, a_err, b_drop, b_err); else pass_cnt++;
    a_sel = 1'b1; b_sel = 2'd3;
    #1;
    total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL reset_ready got a=%b b=%b exp 1 1", a_ready, b_ready); else pass_cnt++;
    step;
  endtask

  task automatic test_route;
    a_data = 8'hA5; a_sel = 1'b1; a_valid = 1'b1; a_oready = 2'b00;
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL route_ready_empty got %b exp 1", a_ready); else pass_cnt++;
    step;
    a_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (a_ovalid !== 2'b10) $display("FAIL route_valid got %b exp 10", a_ovalid); else pass_cnt++;
    total_cnt++; if (a_odata[15:8] !== 8'hA5) $display("FAIL route_data got %h exp a5", a_odata[15:8]); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL route_ready_sel1 got %b exp 0", a_ready); else pass_cnt++;
    a_sel = 1'b0;
    #1;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL route_ready_sel0 got %b exp 1", a_ready); else pass_cnt++;
    step;
    a_oready = 2'b10;
    step;
    a_oready = 2'b00;
    @(negedge clk);
    total_cnt++; if (a_ovalid !== 2'b00) $display("FAIL route_drain got %b exp 00", a_ovalid); else pass_cnt++;
    step;
  endtask

  task automatic test_zero_bubble;
    a_data = 8'h11; a_sel = 1'b0; a_valid = 1'b1; a_oready = 2'b00;
    step;
    a_data = 8'h22; a_oready = 2'b01;
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1 || a_ovalid[0] !== 1'b1 || a_odata[7:0] !== 8'h11) $display("FAIL bubble_pre got r=%b v=%b d=%h exp r=1 v=1 d=11", a_ready, a_ovalid[0], a_odata[7:0]); else pass_cnt++;
    step;
    a_valid = 1'b0; a_oready = 2'b00;
    @(negedge clk);
    total_cnt++; if (a_ovalid !== 2'b01 || a_odata[7:0] !== 8'h22) $display("FAIL bubble_post got v=%b d=%h exp v=01 d=22", a_ovalid, a_odata[7:0]); else pass_cnt++;
    a_oready = 2'b01;
    step;
    a_oready = 2'b00;
    step;
  endtask

  task automatic test_independence;
    logic [7:0] q [$];
    logic [7:0] exp;
    a_data = 8'h77; a_sel = 1'b1; a_valid = 1'b1; a_oready = 2'b00;
    step;
    a_oready = 2'b01;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        a_data = 8'(c + 1); a_sel = 1'b0; a_valid = 1'b1; q.push_back(8'(c + 1));
      end else a_valid = 1'b0;
      @(negedge clk);
      if (c < 16) begin
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL indep_ready c=%0d got %b exp 1", c, a_ready); else pass_cnt++;
      end
      if (c > 0) begin
        exp = q.pop_front();
        total_cnt++; if (a_ovalid[0] !== 1'b1 || a_odata[7:0] !== exp) $display("FAIL indep_port0 c=%0d got v=%b d=%h exp v=1 d=%h", c, a_ovalid[0], a_odata[7:0], exp); else pass_cnt++;
      end
      total_cnt++; if (a_ovalid[1] !== 1'b1 || a_odata[15:8] !== 8'h77) $display("FAIL indep_port1 c=%0d got v=%b d=%h exp v=1 d=77", c, a_ovalid[1], a_odata[15:8]); else pass_cnt++;
      step;
    end
    a_oready = 2'b00;
    @(negedge clk);
    total_cnt++; if (a_ovalid !== 2'b10) $display("FAIL indep_end got %b exp 10", a_ovalid); else pass_cnt++;
    a_oready = 2'b10;
    step;
    a_oready = 2'b00;
    step;
  endtask

  task automatic test_illegal;
    b_sel = 2'd3; b_data = 8'hEE; b_valid = 1'b1; b_oready = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++; if (b_ready !== 1'b1 || b_ovalid !== 3'b000) $display("FAIL illegal_ready i=%0d got r=%b v=%b exp r=1 v=000", i, b_ready, b_ovalid); else pass_cnt++;
      step;
    end
    b_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (b_drop !== 8'd10 || b_err !== 1'b1) $display("FAIL illegal_count got %0d/%b exp 10/1", b_drop, b_err); else pass_cnt++;
    b_valid = 1'b1;
    repeat (250) step;
    b_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (b_drop !== 8'd255 || b_err !== 1'b1) $display("FAIL illegal_sat got %0d/%b exp 255/1", b_drop, b_err); else pass_cnt++;
    total_cnt++; if (b_ovalid !== 3'b000) $display("FAIL illegal_novalid got %b exp 000", b_ovalid); else pass_cnt++;
    step;
  endtask

  task automatic test_mid_reset;
    b_data = 8'h31; b_sel = 2'd0; b_valid = 1'b1; b_oready = 3'b000;
    step;
    b_data = 8'h32; b_sel = 2'd1;
    step;
    b_data = 8'h99; b_sel = 2'd2; rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (b_ovalid !== 3'b011) $display("FAIL rst_pre got %b exp 011", b_ovalid); else pass_cnt++;
    step;
    rst = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (b_ovalid !== 3'b000 || b_odata !== 24'h0) $display("FAIL rst_slots got v=%b d=%h exp v=000 d=000000", b_ovalid, b_odata); else pass_cnt++;
    total_cnt++; if (b_drop !== 8'd0 || b_err !== 1'b0) $display("FAIL rst_drop got %0d/%b exp 0/0", b_drop, b_err); else pass_cnt++;
    b_data = 8'h5A; b_sel = 2'd2; b_valid = 1'b1;
    step;
    b_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (b_ovalid !== 3'b100 || b_odata[23:16] !== 8'h5A) $display("FAIL rst_after got v=%b d=%h exp v=100 d=5a", b_ovalid, b_odata[23:16]); else pass_cnt++;
    b_oready = 3'b100;
    step;
    b_oready = 3'b000;
    step;
  endtask

  task automatic test_back_to_back;
    b_data = 8'h41; b_sel = 2'd0; b_valid = 1'b1; b_oready = 3'b000;
    step;
    b_data = 8'h42; b_sel = 2'd1;
    step;
    b_data = 8'h44; b_sel = 2'd0; b_oready = 3'b011;
    @(negedge clk);
    total_cnt++; if (b_ready !== 1'b1 || b_ovalid !== 3'b011) $display("FAIL b2b_pre got r=%b v=%b exp r=1 v=011", b_ready, b_ovalid); else pass_cnt++;
    step;
    b_valid = 1'b0; b_oready = 3'b000;
    @(negedge clk);
    total_cnt++; if (b_ovalid !== 3'b001 || b_odata[7:0] !== 8'h44) $display("FAIL b2b_post got v=%b d=%h exp v=001 d=44", b_ovalid, b_odata[7:0]); else pass_cnt++;
    b_oready = 3'b001;
    step;
    b_oready = 3'b000;
    step;
  endtask

  task automatic test_random;
    logic exp_ready, exp_v;
    int mdrop;
    mdrop = 0;
    for (int c = 0; c < 400; c++) begin
      b_valid = ($urandom_range(0, 3) != 0);
      b_sel = 2'($urandom_range(0, 3));
      b_data = 8'($urandom);
      b_oready = 3'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_v = (sbq[k].size() != 0);
        total_cnt++; if (b_ovalid[k] !== exp_v) $display("FAIL rand_valid c=%0d port=%0d got %b exp %b", c, k, b_ovalid[k], exp_v); else pass_cnt++;
        if (exp_v) begin
          total_cnt++; if (b_odata[k*8 +: 8] !== sbq[k][0]) $display("FAIL rand_data c=%0d port=%0d got %h exp %h", c, k, b_odata[k*8 +: 8], sbq[k][0]); else pass_cnt++;
        end
      end
      exp_ready = (b_sel == 2'd3) ? 1'b1 : !(sbq[b_sel].size() != 0 && !b_oready[b_sel]);
      total_cnt++; if (b_ready !== exp_ready) $display("FAIL rand_ready c=%0d sel=%0d got %b exp %b", c, b_sel, b_ready, exp_ready); else pass_cnt++;
      for (int k = 0; k < 3; k++)
        if (sbq[k].size() != 0 && b_oready[k]) void'(sbq[k].pop_front());
      if (b_valid && exp_ready) begin
        if (b_sel == 2'd3) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        else sbq[b_sel].push_back(b_data);
      end
      step;
    end
    b_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (b_drop !== 8'(mdrop) || b_err !== (mdrop != 0)) $display("FAIL rand_drop got %0d/%b exp %0d/%b", b_drop, b_err, mdrop, mdrop != 0); else pass_cnt++;
    step;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    a_data = '0; a_sel = '0; a_valid = 1'b0; a_oready = '0;
    b_data = '0; b_sel = '0; b_valid = 1'b0; b_oready = '0;
    pass_cnt = 0; total_cnt = 0;
    step;
    step;
    rst = 1'b0;
    test_reset;
    test_route;
    test_zero_bubble;
    test_independence;
    test_illegal;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
